// File: rtl/trace_pkg.sv
// trace_pkg: shared types and constants for the commit trace checker.
package trace_pkg;

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_UNDERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } gold_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO holding golden commit records, head visible on dout.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  gold_t din,
    output gold_t dout,
    output logic  full,
    output logic  empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    gold_t          mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [AW:0]    cnt;
    logic           do_push, do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (do_pop)
                rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/trace_checker.sv
// trace_checker: compares CPU write-back commits against a golden trace stream
// and reports pass, mismatch, underrun or timeout with first-error capture.
module trace_checker
    import trace_pkg::*;
#(
    parameter logic [31:0] END_PC  = 32'h1c000100,
    parameter int          TIMEOUT = 1000,
    parameter int          DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_we,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic        gold_valid,
    output logic        gold_ready,
    input  logic [31:0] gold_pc,
    input  logic [4:0]  gold_wnum,
    input  logic [31:0] gold_wdata,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [31:0] err_pc,
    output logic [31:0] err_exp,
    output logic [31:0] err_act,
    output logic [31:0] commit_cnt
);
    localparam logic [31:0] TMO = 32'(TIMEOUT);

    state_t      state, state_nxt;
    gold_t       gin, head;
    logic        full, empty, commit, pop, mis, at_end;
    logic [31:0] mask, idle_cnt, idle_nxt, exp_nxt, act_nxt;
    logic [1:0]  code_nxt;

    assign gin        = {gold_pc, gold_wnum, gold_wdata};
    assign gold_ready = !full;
    assign commit     = |debug_wb_rf_we && debug_wb_rf_wnum != 5'd0;
    assign mask       = byte_mask(debug_wb_rf_we);
    assign pop        = state == S_RUN && commit && !empty;
    assign at_end     = debug_wb_pc == END_PC;
    assign mis        = head.pc != debug_wb_pc || head.wnum != debug_wb_rf_wnum ||
                        (head.wdata & mask) != (debug_wb_rf_wdata & mask);
    assign done       = state != S_RUN;
    assign pass       = state == S_PASS;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gold_valid && gold_ready),
        .pop   (pop),
        .din   (gin),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Saturating idle count so a long post-run idle never wraps back under TMO.
    always_comb begin
        idle_nxt  = commit ? '0 : (idle_cnt >= TMO ? idle_cnt : idle_cnt + 1);
        code_nxt  = state != S_RUN          ? ERR_NONE     :
                    commit && empty         ? ERR_UNDERRUN :
                    commit && mis           ? ERR_MISMATCH :
                    at_end                  ? ERR_NONE     :
                    idle_nxt >= TMO         ? ERR_TIMEOUT  : ERR_NONE;
        state_nxt = state != S_RUN          ? state  :
                    code_nxt != ERR_NONE    ? S_FAIL :
                    at_end                  ? S_PASS : S_RUN;
        exp_nxt   = code_nxt == ERR_MISMATCH ? head.wdata & mask : '0;
        act_nxt   = code_nxt == ERR_TIMEOUT  ? '0 : debug_wb_rf_wdata & mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RUN;
            idle_cnt   <= '0;
            commit_cnt <= '0;
            err_code   <= ERR_NONE;
            err_pc     <= '0;
            err_exp    <= '0;
            err_act    <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
            if (pop)
                commit_cnt <= commit_cnt + 1;
            if (code_nxt != ERR_NONE) begin
                err_code <= code_nxt;
                err_pc   <= debug_wb_pc;
                err_exp  <= exp_nxt;
                err_act  <= act_nxt;
            end
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// tb_trace_checker: vector table plus scoreboard bench for trace_checker.
module tb_trace_checker;

    localparam logic [31:0] END_PC = 32'h1c000100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        gold_valid;
    logic        gold_ready;
    logic [31:0] gold_pc;
    logic [4:0]  gold_wnum;
    logic [31:0] gold_wdata;
    logic        done, pass;
    logic [1:0]  err_code;
    logic [31:0] err_pc, err_exp, err_act, commit_cnt;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [1:0]  code;
        logic [31:0] epc;
        logic [31:0] eexp;
        logic [31:0] eact;
        logic [31:0] cnt;
        logic        done;
        logic        pass;
    } vec_t;

    vec_t vecs[11];
    vec_t sb[$];

    trace_checker dut (
        .clk               (clk),
        .rst               (rst),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .gold_valid        (gold_valid),
        .gold_ready        (gold_ready),
        .gold_pc           (gold_pc),
        .gold_wnum         (gold_wnum),
        .gold_wdata        (gold_wdata),
        .done              (done),
        .pass              (pass),
        .err_code          (err_code),
        .err_pc            (err_pc),
        .err_exp           (err_exp),
        .err_act           (err_act),
        .commit_cnt        (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        debug_wb_pc       = '0;
        debug_wb_rf_we    = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        gold_valid        = 1'b0;
        gold_pc           = '0;
        gold_wnum         = '0;
        gold_wdata        = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_gold(input logic [31:0] pc, input logic [4:0] wnum, input logic [31:0] wdata);
        gold_valid = 1'b1;
        gold_pc    = pc;
        gold_wnum  = wnum;
        gold_wdata = wdata;
        step();
        gold_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        chk({tag, " err_code"}, 32'(err_code), 32'(e.code));
        chk({tag, " err_pc"}, err_pc, e.epc);
        chk({tag, " err_exp"}, err_exp, e.eexp);
        chk({tag, " err_act"}, err_act, e.eact);
        chk({tag, " commit_cnt"}, commit_cnt, e.cnt);
        chk({tag, " done"}, 32'(done), 32'(e.done));
        chk({tag, " pass"}, 32'(pass), 32'(e.pass));
    endtask

    task automatic apply_vec(input int i);
        vec_t e;
        debug_wb_pc       = vecs[i].pc;
        debug_wb_rf_we    = vecs[i].we;
        debug_wb_rf_wnum  = vecs[i].wnum;
        debug_wb_rf_wdata = vecs[i].wdata;
        sb.push_back(vecs[i]);
        step();
        idle_inputs();
        e = sb.pop_front();
        check_outputs($sformatf("vec%0d", i), e);
    endtask

    initial begin
        int cycles;
        vec_t z;
        // pc, we, wnum, wdata | code, err_pc, err_exp, err_act, cnt, done, pass
        vecs[0]  = '{32'h1c000000, 4'hf, 5'd1, 32'h00000005, 2'd0, 32'h0, 32'h0, 32'h0, 32'd1, 1'b0, 1'b0};
        vecs[1]  = '{32'h1c000004, 4'hf, 5'd2, 32'h0000000a, 2'd0, 32'h0, 32'h0, 32'h0, 32'd2, 1'b0, 1'b0};
        vecs[2]  = '{32'h1c000008, 4'hf, 5'd3, 32'h0000000f, 2'd0, 32'h0, 32'h0, 32'h0, 32'd3, 1'b0, 1'b0};
        vecs[3]  = '{32'h1c00000c, 4'hf, 5'd0, 32'hdeadbeef, 2'd0, 32'h0, 32'h0, 32'h0, 32'd3, 1'b0, 1'b0};
        vecs[4]  = '{END_PC,       4'h0, 5'd0, 32'h00000000, 2'd0, 32'h0, 32'h0, 32'h0, 32'd3, 1'b1, 1'b1};
        vecs[5]  = '{32'h1c000010, 4'hf, 5'd6, 32'h00000001, 2'd0, 32'h0, 32'h0, 32'h0, 32'd3, 1'b1, 1'b1};
        vecs[6]  = '{32'h1c000000, 4'hf, 5'd1, 32'h00000005, 2'd0, 32'h0, 32'h0, 32'h0, 32'd1, 1'b0, 1'b0};
        vecs[7]  = '{32'h1c000004, 4'hf, 5'd2, 32'h0000000b, 2'd1, 32'h1c000004, 32'h0000000a, 32'h0000000b, 32'd2, 1'b1, 1'b0};
        vecs[8]  = '{END_PC,       4'h0, 5'd0, 32'h00000000, 2'd1, 32'h1c000004, 32'h0000000a, 32'h0000000b, 32'd2, 1'b1, 1'b0};
        vecs[9]  = '{32'h1c000010, 4'hc, 5'd4, 32'h123456ff, 2'd0, 32'h0, 32'h0, 32'h0, 32'd1, 1'b0, 1'b0};
        vecs[10] = '{32'h1c000010, 4'hf, 5'd4, 32'h123456ff, 2'd1, 32'h1c000010, 32'h12345678, 32'h123456ff, 32'd2, 1'b1, 1'b0};
        z = '{32'h0, 4'h0, 5'd0, 32'h0, 2'd0, 32'h0, 32'h0, 32'h0, 32'd0, 1'b0, 1'b0};

        do_reset();
        check_outputs("reset", z);
        chk("reset gold_ready", 32'(gold_ready), 32'd1);

        push_gold(32'h1c000000, 5'd1, 32'h00000005);
        push_gold(32'h1c000004, 5'd2, 32'h0000000a);
        push_gold(32'h1c000008, 5'd3, 32'h0000000f);
        for (int i = 0; i <= 5; i++) apply_vec(i);

        do_reset();
        push_gold(32'h1c000000, 5'd1, 32'h00000005);
        push_gold(32'h1c000004, 5'd2, 32'h0000000a);
        for (int i = 6; i <= 8; i++) apply_vec(i);

        do_reset();
        push_gold(32'h1c000010, 5'd4, 32'h12345678);
        push_gold(32'h1c000010, 5'd4, 32'h12345678);
        for (int i = 9; i <= 10; i++) apply_vec(i);

        // Underrun: commit on empty FIFO while a golden entry arrives the same cycle.
        do_reset();
        debug_wb_pc = 32'h1c000020; debug_wb_rf_we = 4'hf; debug_wb_rf_wnum = 5'd5; debug_wb_rf_wdata = 32'h55;
        gold_valid = 1'b1; gold_pc = 32'h1c000020; gold_wnum = 5'd5; gold_wdata = 32'h55;
        step();
        idle_inputs();
        check_outputs("underrun", '{32'h0, 4'h0, 5'd0, 32'h0, 2'd2, 32'h1c000020, 32'h0, 32'h00000055, 32'd0, 1'b1, 1'b0});

        // Timeout: FIFO fills with no commits, FAIL exactly TIMEOUT cycles after reset release.
        do_reset();
        cycles = 0;
        for (int i = 0; i < 4; i++) begin
            push_gold(32'h1c000000 + 32'(i * 4), 5'd1, 32'(i));
            cycles++;
        end
        chk("full gold_ready", 32'(gold_ready), 32'd0);
        while (!done && cycles < 1100) begin
            step();
            cycles++;
        end
        chk("timeout cycles", 32'(cycles), 32'd1000);
        chk("timeout err_code", 32'(err_code), 32'd3);
        chk("timeout done", 32'(done), 32'd1);
        chk("timeout pass", 32'(pass), 32'd0);

        // Mid-run reset discards FIFO contents and captured error.
        do_reset();
        push_gold(32'h1c000000, 5'd1, 32'h5);
        push_gold(32'h1c000004, 5'd2, 32'ha);
        debug_wb_pc = 32'h1c000000; debug_wb_rf_we = 4'hf; debug_wb_rf_wnum = 5'd1; debug_wb_rf_wdata = 32'h6;
        step();
        idle_inputs();
        chk("pre-reset err_code", 32'(err_code), 32'd1);
        rst = 1'b1;
        step();
        check_outputs("midreset", z);
        chk("midreset gold_ready", 32'(gold_ready), 32'd1);
        rst = 1'b0;
        debug_wb_pc = 32'h1c000004; debug_wb_rf_we = 4'hf; debug_wb_rf_wnum = 5'd2; debug_wb_rf_wdata = 32'ha;
        step();
        idle_inputs();
        chk("post-reset underrun", 32'(err_code), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  - END_PC, 32'h1c000100, write-back PC that ends the run.
  - TIMEOUT, 1000, idle cycles with no commit before failing.
  - DEPTH, 4, golden FIFO entries (power of two).
REQ-002 Ports, one per line: name direction width meaning. Clock and reset come first: reset rst, synchronous, active-high; clock clk.
  - clk in 1 clock
  - rst in 1 synchronous active-high reset
  - debug_wb_pc in 32 write-back PC from CPU
  - debug_wb_rf_we in 4 write-back byte enables
  - debug_wb_rf_wnum in 5 write-back register number
  - debug_wb_rf_wdata in 32 write-back data
  - gold_valid in 1 golden entry offered
  - gold_ready out 1 golden entry accepted
  - gold_pc in 32 expected PC
  - gold_wnum in 5 expected register
  - gold_wdata in 32 expected data
  - done out 1 run finished (sticky)
  - pass out 1 finished with no error (sticky)
  - err_code out 2 0 none, 1 mismatch, 2 underrun, 3 timeout
  - err_pc out 32 actual PC at first error
  - err_exp out 32 expected data at first error
  - err_act out 32 actual data at first error
  - commit_cnt out 32 number of checked commits

Function
REQ-003 Commit event: debug_wb_rf_we != 0 and debug_wb_rf_wnum != 0, sampled every clk; writes to r0 are ignored.
REQ-004 gold_ready = FIFO not full; push on gold_valid & gold_ready; entry = {pc, wnum, wdata}.
REQ-005 FSM states: RUN (after reset), PASS, FAIL; PASS and FAIL are terminal until rst.
REQ-006 In RUN, on a commit with FIFO non-empty: pop the head entry; compare pc and wnum exactly; compare wdata only on bytes whose we bit is 1; commit_cnt += 1.
REQ-007 Any compare mismatch -> FAIL, err_code=1; capture err_pc=debug_wb_pc, err_exp=masked gold wdata, err_act=masked actual wdata.
REQ-008 Commit with FIFO empty -> FAIL, err_code=2, err_exp=0. A push in the same cycle does not bypass; it counts as underrun.
REQ-009 Idle counter: cleared on each commit, else incremented. Reaching TIMEOUT while in RUN -> FAIL, err_code=3.
REQ-010 debug_wb_pc == END_PC while in RUN -> PASS, unless a same-cycle commit fails compare, in which case FAIL wins. Priority: mismatch/underrun > end > timeout.
REQ-011 Outputs are registered. done=1 in PASS or FAIL; pass=1 only in PASS. Error fields are captured once, on the transition into FAIL, and never overwritten.
REQ-012 Push and pop in the same cycle are both allowed while not full. commit_cnt wraps at 2^32. FIFO pointers wrap modulo DEPTH.
REQ-013 In PASS/FAIL the block keeps accepting golden pushes until full but performs no compares; commit_cnt freezes.

Reset
REQ-014 rst: FSM=RUN; FIFO empty (gold_ready=1 the next cycle); done=0, pass=0, err_code=0, err_pc=err_exp=err_act=0, commit_cnt=0, idle counter=0.
REQ-015 rst asserted mid-run discards all FIFO contents and errors; it has priority over every other event.

Structure
REQ-016 Package trace_pkg holds the state enum, the err_code constants and the golden entry struct (69 bits).
REQ-017 One sub-module, trace_fifo: a synchronous DEPTH-entry FIFO with push/pop/full/empty. All other logic lives in trace_checker.

Verification
REQ-018 Push 3 entries {1c000000,r1,00000005},{1c000004,r2,0000000a},{1c000008,r3,0000000f}, then replay matching commits (we=f), then pc=END_PC -> pass=1, done=1, commit_cnt=3, err_code=0.
REQ-019 Expected r2=0000000a, actual r2=0000000b at pc 1c000004 -> FAIL the next cycle, err_code=1, err_pc=1c000004, err_exp=0000000a, err_act=0000000b.
REQ-020 Expected r4 wdata=12345678, actual 123456ff with we=4'b1100 -> no error; the same data with we=4'b1111 -> err_code=1.
REQ-021 Commit r5 with FIFO empty while gold_valid=1 in the same cycle -> err_code=2.
REQ-022 Push 4 entries with no commits -> gold_ready=0; then 1000 idle cycles -> err_code=3, done=1, pass=0.
REQ-023 Commit wnum=0 with we=f -> no pop and commit_cnt unchanged. Assert rst mid-run -> all outputs return to their reset values and gold_ready=1.
